// File: rtl/datapath_mem_responder.sv
// Memory-side responder: serialises datapath fetch/load/store requests onto one RAM port.
// Optional one-entry instruction fetch buffer enabled by defining IFETCH_BUF_EN.
module datapath_mem_responder #(
    parameter int unsigned WAIT_MAX  = 255,
    parameter logic [31:0] LOAD_INIT = 32'h0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic        ram_ack,
    input  logic [31:0] ramload,
    output logic        mem_err
);

    localparam int unsigned DW = 32;
    localparam logic [DW-1:0] TIMEOUT_DATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {IDLE, DACC, IACC, RESP} state_t;
    typedef enum logic [1:0] {OP_IF, OP_RD, OP_WR} op_t;

    state_t        state_q, state_d;
    op_t           op_q, op_d;
    logic          ihit_q, ihit_d, dhit_q, dhit_d;
    logic          ren_q, ren_d, wen_q, wen_d;
    logic          err_q, err_d;
    logic [DW-1:0] ramaddr_q, ramaddr_d, ramstore_q, ramstore_d;
    logic [DW-1:0] imemload_q, imemload_d, dmemload_q, dmemload_d;
    logic [DW-1:0] cnt_q, cnt_d, cnt_inc_c;
    logic          timeout_c;
    logic          buf_hit_c;
    logic [DW-1:0] buf_data_c;

`ifdef IFETCH_BUF_EN
    logic          buf_valid_q;
    logic [29:0]   buf_addr_q;
    logic [DW-1:0] buf_data_q;

    // Filled by every completed RAM fetch; invalidated by a store to the same word.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
        end else if (state_q == IACC && ram_ack) begin
            buf_valid_q <= 1'b1;
            buf_addr_q  <= ramaddr_q[31:2];
            buf_data_q  <= ramload;
        end else if (state_q == DACC && op_q == OP_WR && ramaddr_q[31:2] == buf_addr_q) begin
            buf_valid_q <= 1'b0;
        end
    end

    assign buf_hit_c  = buf_valid_q && (imemaddr[31:2] == buf_addr_q);
    assign buf_data_c = buf_data_q;
`else
    assign buf_hit_c  = 1'b0;
    assign buf_data_c = '0;
`endif

    // Saturating wait counter; timeout fires on the cycle the count reaches WAIT_MAX.
    assign cnt_inc_c = (cnt_q == {DW{1'b1}}) ? cnt_q : cnt_q + DW'(1);
    assign timeout_c = (WAIT_MAX != 0) && (cnt_inc_c == DW'(WAIT_MAX));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            op_q       <= OP_IF;
            ihit_q     <= 1'b0;
            dhit_q     <= 1'b0;
            ren_q      <= 1'b0;
            wen_q      <= 1'b0;
            err_q      <= 1'b0;
            ramaddr_q  <= '0;
            ramstore_q <= '0;
            imemload_q <= LOAD_INIT;
            dmemload_q <= LOAD_INIT;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            ihit_q     <= ihit_d;
            dhit_q     <= dhit_d;
            ren_q      <= ren_d;
            wen_q      <= wen_d;
            err_q      <= err_d;
            ramaddr_q  <= ramaddr_d;
            ramstore_q <= ramstore_d;
            imemload_q <= imemload_d;
            dmemload_q <= dmemload_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        ihit_d     = 1'b0;
        dhit_d     = 1'b0;
        ren_d      = 1'b0;
        wen_d      = 1'b0;
        err_d      = err_q;
        ramaddr_d  = ramaddr_q;
        ramstore_d = ramstore_q;
        imemload_d = imemload_q;
        dmemload_d = dmemload_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (dmemWEN || dmemREN) begin
                    op_d       = dmemWEN ? OP_WR : OP_RD;
                    ramaddr_d  = {dmemaddr[31:2], 2'b00};
                    ramstore_d = dmemstore;
                    wen_d      = dmemWEN;
                    ren_d      = !dmemWEN;
                    cnt_d      = '0;
                    state_d    = DACC;
                end else if (imemREN && buf_hit_c) begin
                    op_d       = OP_IF;
                    ihit_d     = 1'b1;
                    imemload_d = buf_data_c;
                    state_d    = RESP;
                end else if (imemREN) begin
                    op_d      = OP_IF;
                    ramaddr_d = {imemaddr[31:2], 2'b00};
                    ren_d     = 1'b1;
                    cnt_d     = '0;
                    state_d   = IACC;
                end
            end
            DACC, IACC: begin
                if (ram_ack || timeout_c) begin
                    state_d = RESP;
                    ihit_d  = (op_q == OP_IF);
                    dhit_d  = (op_q != OP_IF);
                    err_d   = err_q || !ram_ack;
                    if (op_q == OP_IF) imemload_d = ram_ack ? ramload : TIMEOUT_DATA;
                    if (op_q == OP_RD) dmemload_d = ram_ack ? ramload : TIMEOUT_DATA;
                end else begin
                    ren_d = ren_q;
                    wen_d = wen_q;
                    cnt_d = cnt_inc_c;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign ihit     = ihit_q;
    assign dhit     = dhit_q;
    assign ramREN   = ren_q;
    assign ramWEN   = wen_q;
    assign ramaddr  = ramaddr_q;
    assign ramstore = ramstore_q;
    assign imemload = imemload_q;
    assign dmemload = dmemload_q;
    assign mem_err  = err_q;

endmodule
